jtframe_sdram_bank_client: RTL

JTFRAME_SDRAM_BANK_CLIENT -- requirements
Module: jtframe_sdram_bank_client

---
 rtl/jtframe_sdram_pkg.sv | 21 ++
 rtl/jtframe_sdram_client_mux.sv | 33 +++
 rtl/jtframe_sdram_bank_client.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/jtframe_sdram_pkg.sv
// Shared types and helpers for the SDRAM bank client.
// Holds the client FSM state encoding and the slot-width to word-address shift.
package jtframe_sdram_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_ACK = 2'd1,
        ST_WAIT_RDY = 2'd2
    } state_t;

    // Shift that turns a DW-sized slot address into a 16-bit word address:
    // negative = shift right, positive = shift left.
    function automatic int word_shift(input int dw);
        case (dw)
            8:       return -1;
            32:      return 1;
            default: return 0;
        endcase
    endfunction

endpackage

// File: rtl/jtframe_sdram_client_mux.sv
// Read data select for the SDRAM bank client.
// Picks the slot-sized value out of the 32-bit line: whole line for DW=32,
// one 16-bit word for DW=16, one byte of the selected word for DW=8.
module jtframe_sdram_client_mux
    import jtframe_sdram_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic [31:0]   line,
    input  logic          word_sel,
    input  logic          byte_sel,
    output logic [DW-1:0] data
);

    logic [15:0] word;
    logic        unused_sel;

    assign word = word_sel ? line[31:16] : line[15:0];

    generate
        if (DW == 32) begin : g_dw32
            assign data       = line;
            assign unused_sel = ^{word, word_sel, byte_sel};
        end else if (DW == 8) begin : g_dw8
            assign data       = byte_sel ? word[15:8] : word[7:0];
            assign unused_sel = 1'b0;
        end else begin : g_dw16
            assign data       = word;
            assign unused_sel = byte_sel;
        end
    endgenerate

endmodule

// File: rtl/jtframe_sdram_bank_client.sv
// SDRAM bank client: turns a level-held game-side read (addr/cs) into
// 32-bit line fetches on a bank port and serves dout from the line register.
//
// Build option: JTFRAME_SDRAM_CLIENT_CACHE_EN
//   defined   - the line register is a one-line cache; hits skip the bank.
//   undefined - the line is dropped whenever cs falls or addr moves, so every
//               new access fetches again.
//
// state       | meaning
// ------------+---------------------------------------------------------
// ST_IDLE     | no fetch in flight; hits drive ok, misses issue ba_rd
// ST_WAIT_ACK | ba_rd held high until the controller takes the request
// ST_WAIT_RDY | request accepted, waiting for the line on din
module jtframe_sdram_bank_client
    import jtframe_sdram_pkg::*;
#(
    parameter int AW  = 22,
    parameter int DW  = 16,
    parameter int BAW = 22
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [AW-1:0]  addr,
    input  logic           cs,
    input  logic           clr,
    output logic           ok,
    output logic [DW-1:0]  dout,
    output logic [BAW-1:0] ba_addr,
    output logic           ba_rd,
    input  logic           ba_ack,
    input  logic           ba_rdy,
    input  logic [31:0]    din
);

    localparam int WSH = word_shift(DW);
    localparam int XW  = (AW + 1 > BAW) ? AW + 1 : BAW;

    state_t         state;
    logic [31:0]    line;
    logic [BAW-1:0] tag;
    logic           valid;
    logic           clr_pend;

    logic [XW-1:0]  addr_x;
    logic [XW-1:0]  word_x;
    logic [BAW-1:0] word_addr;
    logic [BAW-1:0] line_addr;
    logic           unused_hi;

    logic           fill;
    logic           fresh;
    logic           hit;
    logic [31:0]    line_n;
    logic [BAW-1:0] tag_n;
    logic           valid_n;
    logic           ok_n;
    logic [DW-1:0]  mux_data;

    assign addr_x = XW'(addr);

    generate
        if (WSH < 0) begin : g_shr
            assign word_x = addr_x >> 1;
        end else if (WSH > 0) begin : g_shl
            assign word_x = addr_x << 1;
        end else begin : g_same
            assign word_x = addr_x;
        end
    endgenerate

    assign word_addr = word_x[BAW-1:0];
    assign line_addr = {word_addr[BAW-1:1], 1'b0};
    assign unused_hi = ^word_x;

`ifdef JTFRAME_SDRAM_CLIENT_CACHE_EN
    assign fresh = 1'b1;
`else
    logic [AW-1:0] addr_q;

    // Previous address, used to spot a new access within the same line
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q <= '0;
        end else begin
            addr_q <= addr;
        end
    end

    assign fresh = cs && (addr == addr_q);
`endif

    assign hit = valid && fresh && (tag == line_addr);

    // Next line/tag/valid: a fill loads din, clr (now or during the fetch) kills valid
    always_comb begin
        fill    = ((state == ST_WAIT_ACK) && ba_ack && ba_rdy) ||
                  ((state == ST_WAIT_RDY) && ba_rdy);
        line_n  = fill ? din : line;
        tag_n   = fill ? ba_addr : tag;
        valid_n = fill ? !(clr || clr_pend) : valid;
        if (clr) begin
            valid_n = 1'b0;
        end
`ifndef JTFRAME_SDRAM_CLIENT_CACHE_EN
        if (!cs || (addr != addr_q)) begin
            valid_n = 1'b0;
        end
`endif
        ok_n = cs && valid_n && (tag_n == line_addr);
    end

    jtframe_sdram_client_mux #(
        .DW(DW)
    ) u_mux (
        .line     (line_n),
        .word_sel (word_addr[0]),
        .byte_sel (addr[0]),
        .data     (mux_data)
    );

    // Request FSM plus the line, tag, valid, ok and dout registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            ba_rd    <= 1'b0;
            ba_addr  <= '0;
            ok       <= 1'b0;
            dout     <= '0;
            line     <= '0;
            tag      <= '0;
            valid    <= 1'b0;
            clr_pend <= 1'b0;
        end else begin
            line  <= line_n;
            tag   <= tag_n;
            valid <= valid_n;
            dout  <= mux_data;
            ok    <= 1'b0;

            if (fill || (state == ST_IDLE)) begin
                clr_pend <= 1'b0;
            end else if (clr) begin
                clr_pend <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (cs && !hit) begin
                        ba_rd   <= 1'b1;
                        ba_addr <= line_addr;
                        state   <= ST_WAIT_ACK;
                    end else begin
                        ok <= ok_n;
                    end
                end
                ST_WAIT_ACK: begin
                    if (ba_ack) begin
                        ba_rd <= 1'b0;
                        if (ba_rdy) begin
                            ok    <= ok_n;
                            state <= ST_IDLE;
                        end else begin
                            state <= ST_WAIT_RDY;
                        end
                    end
                end
                ST_WAIT_RDY: begin
                    if (ba_rdy) begin
                        ok    <= ok_n;
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    ba_rd <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
